data_stream_mux: RTL and testbench
==================================

Name: data_stream_mux

Overview:
Parametrised successor to the two-channel left/right data stream block. Merges CH_NUM valid/ready channel streams into one output stream, framed by an external sync strobe. Each frame holds, per channel in ascending order, one header word followed by exactly BURST_LEN data words from that channel. Sits between the per-channel acquisition front ends and the memory-copy / packet path.

Parameters:
CH_NUM, 2, number of input channels (1..16)
DATA_W, 32, word width of every input and the output (must be >= 32)
BURST_LEN, 32, data words taken per channel per frame (2..65535)
FCNT_W, 16, frame counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_sync  in  1  frame sync, active-low, asynchronous to frame content
o_sync_pulse  out  1  one-cycle pulse on detected falling edge of i_sync
i_data  in  CH_NUM*DATA_W  channel data; channel k occupies bits [k*DATA_W +: DATA_W]
i_valid  in  CH_NUM  per-channel valid
o_ready  out  CH_NUM  per-channel ready
o_data  out  DATA_W  merged output word
o_valid  out  1  output valid
i_ready  in  1  downstream ready
o_sof  out  1  qualifies first word of frame (channel 0 header)
o_eof  out  1  qualifies last data word of last channel
o_abort  out  1  one-cycle pulse when a frame is cut short by sync
o_frame_cnt  out  FCNT_W  frames started since reset
o_busy  out  1  high in HDR or DATA

Behaviour:
- Reset is rst_n, asynchronous, active-low; the clock is clk.
- Reset values: o_sync_pulse, o_valid, o_sof, o_eof, o_abort, o_busy = 0; o_ready = 0; o_data = 0; o_frame_cnt = 0; state = IDLE; i_sync history register = 1.
- Sync detection: sync_d <= i_sync every clk. o_sync_pulse is a register set to (sync_d & ~i_sync), so it is high for exactly one cycle. A low level held on i_sync gives no further pulses.
- Transfer: the cycle in which o_valid & i_ready (output) or i_valid[k] & o_ready[k] (input) are both high.
- FSM states: IDLE, HDR, DATA, DONE. Registers: ch (4 bit) and wcnt (16 bit).
- IDLE and DONE:
  - o_valid = 0, o_ready = 0.
  - On o_sync_pulse: go to HDR, ch = 0, o_frame_cnt += 1 (wraps modulo 2^FCNT_W).
- HDR:
  - o_valid = 1.
  - o_data = {ch in bits [31:28], 12'h000, o_frame_cnt[15:0]}; bits above 31 are zero.
  - o_sof = (ch == 0).
  - o_ready = 0.
  - On transfer: go to DATA, wcnt = 0.
- DATA:
  - o_data = i_data[ch]; o_valid = i_valid[ch].
  - o_ready[ch] = i_ready, combinational pass-through, zero latency. All other o_ready bits = 0.
  - On transfer, wcnt += 1.
  - On the transfer with wcnt == BURST_LEN-1:
    - if ch < CH_NUM-1: ch += 1, go to HDR;
    - otherwise go to DONE, with o_eof high on that word.
- o_data, o_valid, o_sof and o_eof are combinational from state, ch and the selected channel. Output latency from an input word to o_data is 0 cycles.
- Frame length = CH_NUM*(BURST_LEN+1) words.
- Sync while in HDR or DATA:
  - The o_sync_pulse cycle has priority over the FSM advance.
  - Go to HDR with ch = 0, o_frame_cnt += 1, and o_abort pulses in the same cycle.
  - A handshake occurring in that cycle still completes on both sides and is not replayed.
  - The aborted frame gets no o_eof.
- An i_valid[ch] deassert mid-burst stalls output (o_valid = 0) with no timeout.
- Downstream backpressure holds o_data and o_valid stable; upstream is held via o_ready.
- Reset asserted mid-frame returns every register to its reset value immediately. No output is produced until the next sync falling edge after reset.

Test Plan:
- CH_NUM=2, BURST_LEN=32, i_ready=1, both channels always valid; one i_sync low pulse -> o_sync_pulse high 1 cycle; 66 words out; header0 = 0x00000001 with o_sof; header1 = 0x10000001; o_eof on word 66; then DONE with o_valid=0.
- Same setup, i_ready low for 100 cycles at word 10 -> o_data held constant, o_ready=2'b00 throughout; sequence resumes unchanged; total still 66 words.
- Channel 1 i_valid dropped for 20 cycles mid-burst -> o_valid=0 for those cycles; no word lost or duplicated; per-channel counters in the stream are contiguous.
- Second sync arrives at word 40 -> o_abort pulses; next word is header 0x00000002 with o_sof; no o_eof for frame 1.
- i_sync held low for 1000 cycles -> exactly one o_sync_pulse; rst_n asserted mid-DATA -> o_valid=0, o_frame_cnt=0, o_ready=0 on the same edge.
- CH_NUM=4, DATA_W=64, BURST_LEN=2 -> 12 words per frame; headers carry ch 0..3 in bits [31:28] and zeros in bits [63:32].

Source files
------------

// File: rtl/data_stream_mux.sv
// Merges CH_NUM valid/ready channel streams into one framed output stream.
// A frame is, per channel in ascending order, one header word then BURST_LEN data words.
//
// state | meaning
// IDLE  | no frame since reset; waiting for a sync falling edge
// HDR   | presenting the header word for channel ch
// DATA  | passing channel ch through, wcnt words already taken
// DONE  | frame complete; waiting for the next sync falling edge
module data_stream_mux #(
  parameter int CH_NUM    = 2,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 32,
  parameter int FCNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_sync,
  output logic                     o_sync_pulse,
  input  logic [CH_NUM*DATA_W-1:0] i_data,
  input  logic [CH_NUM-1:0]        i_valid,
  output logic [CH_NUM-1:0]        o_ready,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_sof,
  output logic                     o_eof,
  output logic                     o_abort,
  output logic [FCNT_W-1:0]        o_frame_cnt,
  output logic                     o_busy
);

  typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

  state_t             state, state_nxt;
  logic [3:0]         ch, ch_nxt;
  logic [15:0]        wcnt, wcnt_nxt;
  logic [FCNT_W-1:0]  fcnt, fcnt_nxt;
  logic               sync_d;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_valid;
  logic               last_word;
  logic               last_ch;
  logic               xfer;
  logic [15:0]        fc16;
  logic [31:0]        hdr_word;

  // Header carries the low 16 bits of the frame counter, zero-extended if narrower.
  if (FCNT_W >= 16) begin : g_fc
    assign fc16 = fcnt[15:0];
  end else begin : g_fc
    assign fc16 = {{(16-FCNT_W){1'b0}}, fcnt};
  end

  assign hdr_word    = {ch, 12'h000, fc16};
  assign last_word   = (wcnt == 16'(BURST_LEN-1));
  assign last_ch     = (ch == 4'(CH_NUM-1));
  assign xfer        = o_valid & i_ready;
  assign o_frame_cnt = fcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_d       <= 1'b1;
      o_sync_pulse <= 1'b0;
    end else begin
      sync_d       <= i_sync;
      o_sync_pulse <= sync_d & ~i_sync;
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (ch == 4'(k)) begin
        sel_data  = i_data[k*DATA_W +: DATA_W];
        sel_valid = i_valid[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ch    <= '0;
      wcnt  <= '0;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      ch    <= ch_nxt;
      wcnt  <= wcnt_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ch_nxt    = ch;
    wcnt_nxt  = wcnt;
    fcnt_nxt  = fcnt;
    case (state)
      HDR: begin
        if (xfer) begin
          state_nxt = DATA;
          wcnt_nxt  = '0;
        end
      end
      DATA: begin
        if (xfer) begin
          wcnt_nxt = wcnt + 16'd1;
          if (last_word) begin
            if (!last_ch) begin
              ch_nxt    = ch + 4'd1;
              state_nxt = HDR;
            end else begin
              state_nxt = DONE;
            end
          end
        end
      end
      default: ;
    endcase
    // A sync edge restarts the frame from any state; the handshake of this cycle is not replayed.
    if (o_sync_pulse) begin
      state_nxt = HDR;
      ch_nxt    = '0;
      wcnt_nxt  = '0;
      fcnt_nxt  = fcnt + 1'b1;
    end
  end

  always_comb begin
    o_valid = 1'b0;
    o_data  = '0;
    o_ready = '0;
    o_sof   = 1'b0;
    o_eof   = 1'b0;
    o_busy  = 1'b0;
    case (state)
      HDR: begin
        o_valid       = 1'b1;
        o_data[31:0]  = hdr_word;
        o_sof         = (ch == 4'd0);
        o_busy        = 1'b1;
      end
      DATA: begin
        o_valid = sel_valid;
        o_data  = sel_data;
        o_eof   = sel_valid & last_word & last_ch;
        o_busy  = 1'b1;
        for (int k = 0; k < CH_NUM; k++) begin
          if (ch == 4'(k)) o_ready[k] = i_ready;
        end
      end
      default: ;
    endcase
    o_abort = o_sync_pulse & o_busy;
  end

endmodule

// File: tb/tb_data_stream_mux.sv
// Directed bench for data_stream_mux: 2ch x 32 words (with a per-cycle stream model) and 4ch x 64b x 2 words.
module tb_data_stream_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_sync, a_rdy, a_pulse, a_ovalid, a_sof, a_eof, a_abort, a_busy;
  logic [63:0] a_data;
  logic [1:0]  a_valid, a_oready;
  logic [31:0] a_odata;
  logic [15:0] a_fcnt;

  logic         b_sync, b_rdy, b_pulse, b_ovalid, b_sof, b_eof, b_abort, b_busy;
  logic [255:0] b_data;
  logic [3:0]   b_valid, b_oready;
  logic [63:0]  b_odata;
  logic [15:0]  b_fcnt;

  data_stream_mux #(.CH_NUM(2), .DATA_W(32), .BURST_LEN(32), .FCNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_sync(a_sync), .o_sync_pulse(a_pulse),
    .i_data(a_data), .i_valid(a_valid), .o_ready(a_oready),
    .o_data(a_odata), .o_valid(a_ovalid), .i_ready(a_rdy),
    .o_sof(a_sof), .o_eof(a_eof), .o_abort(a_abort),
    .o_frame_cnt(a_fcnt), .o_busy(a_busy)
  );

  data_stream_mux #(.CH_NUM(4), .DATA_W(64), .BURST_LEN(2), .FCNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_sync(b_sync), .o_sync_pulse(b_pulse),
    .i_data(b_data), .i_valid(b_valid), .o_ready(b_oready),
    .o_data(b_odata), .o_valid(b_ovalid), .i_ready(b_rdy),
    .o_sof(b_sof), .o_eof(b_eof), .o_abort(b_abort),
    .o_frame_cnt(b_fcnt), .o_busy(b_busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // stream model for dut_a
  int          cnt_a[2];
  int          out_cnt[2];
  int          widx, fc_exp;
  logic        in_frame, sd1, sd2;
  int          words, eofs, pulses, aborts, stall_cyc;
  logic [31:0] hdr0, hdr1;

  task automatic cycle_a(input logic sync, input logic [1:0] vld, input logic rdy);
    int c, pos;
    logic e_pulse, e_valid, e_sof, e_eof, e_abort;
    logic [1:0]  e_ready;
    logic [31:0] e_data;
    @(negedge clk);
    a_sync  = sync;
    a_valid = vld;
    a_rdy   = rdy;
    for (int k = 0; k < 2; k++)
      a_data[k*32 +: 32] = 32'hA000_0000 | (32'(k) << 24) | 32'(cnt_a[k]);
    #1;
    e_pulse = sd2 & ~sd1;
    c   = widx / 33;
    pos = widx % 33;
    if (c > 1) c = 1;
    e_valid = in_frame && (pos == 0 || vld[c]);
    e_ready = (in_frame && pos != 0 && rdy) ? (2'b01 << c) : 2'b00;
    e_sof   = in_frame && (widx == 0);
    e_eof   = in_frame && (widx == 65) && vld[1];
    e_abort = e_pulse && in_frame;
    e_data  = (pos == 0) ? {4'(c), 12'h000, 16'(fc_exp)}
                         : (32'hA000_0000 | (32'(c) << 24) | 32'(out_cnt[c]));
    chk("ctl", {a_ovalid, a_sof, a_eof, a_oready, a_busy, a_abort, a_pulse},
               {e_valid, e_sof, e_eof, e_ready, in_frame, e_abort, e_pulse});
    chk("fcnt", a_fcnt, 16'(fc_exp));
    if (e_valid) chk("data", a_odata, e_data);
    if (!e_valid && in_frame) stall_cyc++;
    if (a_pulse) pulses++;
    if (a_abort) aborts++;
    if (e_valid && rdy) begin
      if (pos != 0) out_cnt[c]++;
      if (widx == 0)  hdr0 = a_odata;
      if (widx == 33) hdr1 = a_odata;
      if (a_eof) eofs++;
      words++;
      widx++;
      if (widx == 66) in_frame = 1'b0;
    end
    for (int k = 0; k < 2; k++) if (vld[k] && a_oready[k]) cnt_a[k]++;
    if (e_pulse) begin
      in_frame = 1'b1;
      widx     = 0;
      fc_exp++;
    end
    sd2 = sd1;
    sd1 = sync;
  endtask

  task automatic clr_stats();
    words = 0; eofs = 0; pulses = 0; aborts = 0; stall_cyc = 0;
  endtask

  initial begin
    int g, n, stall;
    logic stalled, r, s;
    logic [1:0] v;
    logic [63:0] exp_b[12];
    logic [63:0] got_b[12];
    logic [11:0] sofs, eofs_b;

    rst_n = 1'b0;
    a_sync = 1'b1; a_valid = '0; a_rdy = 1'b0; a_data = '0;
    b_sync = 1'b1; b_valid = '0; b_rdy = 1'b0; b_data = '0;
    cnt_a = '{0, 0}; out_cnt = '{0, 0};
    widx = 0; fc_exp = 0; in_frame = 1'b0; sd1 = 1'b1; sd2 = 1'b1;
    hdr0 = '0; hdr1 = '0;
    clr_stats();
    #12;
    chk("rst_a_ctl", {a_ovalid, a_sof, a_eof, a_oready, a_busy, a_abort, a_pulse}, 8'h00);
    chk("rst_a_data", a_odata, 32'h0);
    chk("rst_a_fcnt", a_fcnt, 16'h0);
    chk("rst_b_ctl", {b_ovalid, b_sof, b_eof, b_oready, b_busy, b_abort, b_pulse}, 10'h000);
    chk("rst_b_data", b_odata, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // frame 1: plain run
    clr_stats();
    cycle_a(1'b0, 2'b11, 1'b1);
    g = 0;
    while ((in_frame || pulses == 0) && g < 300) begin cycle_a(1'b1, 2'b11, 1'b1); g++; end
    chk("t1_cycles", g, 67);
    chk("t1_words", words, 66);
    chk("t1_eofs", eofs, 1);
    chk("t1_pulses", pulses, 1);
    chk("t1_hdr0", hdr0, 32'h0000_0001);
    chk("t1_hdr1", hdr1, 32'h1000_0001);
    repeat (3) cycle_a(1'b1, 2'b11, 1'b1);

    // frame 2: 100 cycles of backpressure at word 10
    clr_stats();
    stalled = 1'b0; stall = 0;
    cycle_a(1'b0, 2'b11, 1'b1);
    g = 0;
    while ((in_frame || pulses == 0) && g < 400) begin
      r = 1'b1;
      if (in_frame && widx == 10 && !stalled) begin stalled = 1'b1; stall = 100; end
      if (stall > 0) begin r = 1'b0; stall--; end
      cycle_a(1'b1, 2'b11, r);
      g++;
    end
    chk("t2_cycles", g, 167);
    chk("t2_words", words, 66);
    chk("t2_eofs", eofs, 1);
    chk("t2_hdr0", hdr0, 32'h0000_0002);

    // frame 3: channel 1 valid dropped for 20 cycles
    clr_stats();
    stalled = 1'b0; stall = 0;
    cycle_a(1'b0, 2'b11, 1'b1);
    g = 0;
    while ((in_frame || pulses == 0) && g < 300) begin
      v = 2'b11;
      if (in_frame && widx == 44 && !stalled) begin stalled = 1'b1; stall = 20; end
      if (stall > 0) begin v = 2'b01; stall--; end
      cycle_a(1'b1, v, 1'b1);
      g++;
    end
    chk("t3_cycles", g, 87);
    chk("t3_stall", stall_cyc, 20);
    chk("t3_words", words, 66);
    chk("t3_hdr1", hdr1, 32'h1000_0003);

    // frame 4 aborted by a sync at word 40, frame 5 runs to completion
    clr_stats();
    stalled = 1'b0;
    cycle_a(1'b0, 2'b11, 1'b1);
    g = 0;
    while ((in_frame || pulses == 0) && g < 300) begin
      s = 1'b1;
      if (in_frame && widx == 40 && !stalled) begin stalled = 1'b1; s = 1'b0; end
      cycle_a(s, 2'b11, 1'b1);
      g++;
    end
    chk("t4_cycles", g, 109);
    chk("t4_aborts", aborts, 1);
    chk("t4_pulses", pulses, 2);
    chk("t4_eofs", eofs, 1);
    chk("t4_words", words, 108);
    chk("t4_hdr0", hdr0, 32'h0000_0005);

    // sync held low: one pulse only
    clr_stats();
    repeat (1000) cycle_a(1'b0, 2'b11, 1'b1);
    chk("t5_pulses", pulses, 1);
    chk("t5_words", words, 66);
    chk("t5_eofs", eofs, 1);
    repeat (2) cycle_a(1'b1, 2'b11, 1'b1);

    // reset in the middle of channel 1 data
    cycle_a(1'b0, 2'b11, 1'b1);
    g = 0;
    while (!(in_frame && widx == 50) && g < 100) begin cycle_a(1'b1, 2'b11, 1'b1); g++; end
    chk("t6_reach", g < 100, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", a_ovalid, 1'b0);
    chk("t6_ready", a_oready, 2'b00);
    chk("t6_fcnt", a_fcnt, 16'h0);
    chk("t6_busy", a_busy, 1'b0);
    in_frame = 1'b0; widx = 0; fc_exp = 0; sd1 = 1'b1; sd2 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) cycle_a(1'b1, 2'b11, 1'b1);
    clr_stats();
    cycle_a(1'b0, 2'b11, 1'b1);
    g = 0;
    while ((in_frame || pulses == 0) && g < 300) begin cycle_a(1'b1, 2'b11, 1'b1); g++; end
    chk("t6_words", words, 66);
    chk("t6_hdr0", hdr0, 32'h0000_0001);

    // 4 channels, 64-bit words, burst of 2
    exp_b[0]  = 64'h0000_0000_0000_0001;
    exp_b[1]  = 64'hFFFF_0000_1234_5600;
    exp_b[2]  = 64'hFFFF_0000_1234_5600;
    exp_b[3]  = 64'h0000_0000_1000_0001;
    exp_b[4]  = 64'hFFFF_0001_1234_5601;
    exp_b[5]  = 64'hFFFF_0001_1234_5601;
    exp_b[6]  = 64'h0000_0000_2000_0001;
    exp_b[7]  = 64'hFFFF_0002_1234_5602;
    exp_b[8]  = 64'hFFFF_0002_1234_5602;
    exp_b[9]  = 64'h0000_0000_3000_0001;
    exp_b[10] = 64'hFFFF_0003_1234_5603;
    exp_b[11] = 64'hFFFF_0003_1234_5603;
    @(negedge clk);
    for (int k = 0; k < 4; k++)
      b_data[k*64 +: 64] = {32'hFFFF_0000 + 32'(k), 32'h1234_5600 + 32'(k)};
    b_valid = 4'hF;
    b_rdy   = 1'b1;
    b_sync  = 1'b0;
    @(negedge clk);
    b_sync = 1'b1;
    n = 0; g = 0; sofs = '0; eofs_b = '0;
    for (int i = 0; i < 12; i++) got_b[i] = '0;
    while (n < 12 && g < 60) begin
      #1;
      if (b_ovalid && b_rdy) begin
        got_b[n]  = b_odata;
        sofs[n]   = b_sof;
        eofs_b[n] = b_eof;
        n++;
      end
      g++;
      @(negedge clk);
    end
    chk("b_words", n, 12);
    for (int i = 0; i < 12; i++) chk($sformatf("b_w%0d", i), got_b[i], exp_b[i]);
    chk("b_sof", sofs, 12'h001);
    chk("b_eof", eofs_b, 12'h800);
    #1;
    chk("b_done", {b_ovalid, b_busy}, 2'b00);
    chk("b_fcnt", b_fcnt, 16'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
